booth_encoder_premult: RTL

Pipelined front end of the radix-8 MBE multiplier; feeds the Booth selector unit directly. Accepts one 24-bit unsigned multiplicand/multiplier pair per cycle under valid/ready and produces the four multiples x, 2x, 3x and 4x, 27 bits each. It also produces nine 5-bit Booth select codes. The hard multiple 3x is split across two pipeline stages to keep the adder off the critical path.

---
 rtl/r8_mbe_pkg.sv | 18 +
 rtl/booth_encoder.sv | 30 +++
 rtl/booth_encoder_premult.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/r8_mbe_pkg.sv
// Shared definitions for the radix-8 modified-Booth multiplier front end
// and the Booth selector unit that consumes its select codes.
package r8_mbe_pkg;

    localparam int N    = 24;
    localparam int PP_W = 27;
    localparam int NPP  = 9;

    // Select code: bit 4 is the negate flag, bits [3:0] a one-hot magnitude.
    typedef logic [4:0] be_sel_t;

    localparam be_sel_t SEL_1X = 5'b00001;
    localparam be_sel_t SEL_2X = 5'b00010;
    localparam be_sel_t SEL_3X = 5'b00100;
    localparam be_sel_t SEL_4X = 5'b01000;
    localparam int      SEL_NEG = 4;

endpackage

// File: rtl/booth_encoder.sv
// Radix-8 Booth digit encoder: maps one overlapping 4-bit multiplier group
// {b[3i+2], b[3i+1], b[3i], b[3i-1]} onto a signed one-hot select code.
module booth_encoder
    import r8_mbe_pkg::*;
(
    input  logic [3:0] grp,
    output be_sel_t    sel
);

    logic neg;

    // Digit = -4*g3 + 2*g2 + g1 + g0; zero digits never carry the negate flag.
    always_comb begin
        sel = '0;
        neg = 1'b0;
        unique case (grp)
            4'b0001, 4'b0010: sel = SEL_1X;
            4'b0011, 4'b0100: sel = SEL_2X;
            4'b0101, 4'b0110: sel = SEL_3X;
            4'b0111:          sel = SEL_4X;
            4'b1000:          begin sel = SEL_4X; neg = 1'b1; end
            4'b1001, 4'b1010: begin sel = SEL_3X; neg = 1'b1; end
            4'b1011, 4'b1100: begin sel = SEL_2X; neg = 1'b1; end
            4'b1101, 4'b1110: begin sel = SEL_1X; neg = 1'b1; end
            default:          sel = '0;
        endcase
        sel[SEL_NEG] = neg;
    end

endmodule

// File: rtl/booth_encoder_premult.sv
// Two-stage pipelined front end of the radix-8 MBE multiplier: produces the
// multiples a, 2a, 3a, 4a and nine Booth select codes under valid/ready.
// The 3a adder is split at bit 13 so each stage carries only half of it.
module booth_encoder_premult
    import r8_mbe_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         a,
    input  logic [N-1:0]         b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PP_W-1:0]      x_1,
    output logic [PP_W-1:0]      x_2,
    output logic [PP_W-1:0]      x_3,
    output logic [PP_W-1:0]      x_4,
    output be_sel_t [NPP-1:0]    BEU_sel
);

    localparam int LO_W = 13;

    logic            s1_en;
    logic            s2_en;

    logic            v1_q,  v1_d;
    logic [N-1:0]    a1_q,  a1_d;
    logic [N-1:0]    b1_q,  b1_d;
    logic [LO_W-1:0] lo1_q, lo1_d;
    logic            cy1_q, cy1_d;

    logic            v2_q,  v2_d;
    logic [PP_W-1:0] x1_q,  x1_d;
    logic [PP_W-1:0] x2_q,  x2_d;
    logic [PP_W-1:0] x3_q,  x3_d;
    logic [PP_W-1:0] x4_q,  x4_d;
    be_sel_t [NPP-1:0] sel_q, sel_d;

    logic [LO_W:0]   sum_lo;
    logic [LO_W-1:0] sum_hi;
    logic [27:0]     b_ext;
    be_sel_t [NPP-1:0] enc_sel;

    // Stage-wise handshake: a stage may load when it is empty or its successor moves.
    always_comb begin
        s2_en    = !v2_q || out_ready;
        s1_en    = !v1_q || s2_en;
        in_ready = s1_en;
    end

    // Stage 1 next state: capture operands and the low 13 bits of 3a plus carry.
    always_comb begin
        sum_lo = {1'b0, a[LO_W-1:0]} + {1'b0, a[LO_W-2:0], 1'b0};
        v1_d   = v1_q;
        a1_d   = a1_q;
        b1_d   = b1_q;
        lo1_d  = lo1_q;
        cy1_d  = cy1_q;
        if (s1_en) begin
            v1_d = in_valid;
            if (in_valid) begin
                a1_d  = a;
                b1_d  = b;
                lo1_d = sum_lo[LO_W-1:0];
                cy1_d = sum_lo[LO_W];
            end
        end
    end

    // Multiplier with b[-1]=0 at index 0 and zero-extension above bit 23.
    assign b_ext = {3'b000, b1_q, 1'b0};

    for (genvar g = 0; g < NPP; g++) begin : g_enc
        booth_encoder u_enc (
            .grp (b_ext[3*g+3 -: 4]),
            .sel (enc_sel[g])
        );
    end

    // Stage 2 next state: finish 3a's upper half and latch multiples and codes.
    always_comb begin
        sum_hi = {2'b00, a1_q[N-1:LO_W]} + {1'b0, a1_q[N-1:LO_W-1]}
               + {{(LO_W-1){1'b0}}, cy1_q};
        v2_d   = v2_q;
        x1_d   = x1_q;
        x2_d   = x2_q;
        x3_d   = x3_q;
        x4_d   = x4_q;
        sel_d  = sel_q;
        if (s2_en) begin
            v2_d = v1_q;
            if (v1_q) begin
                x1_d  = {3'b000, a1_q};
                x2_d  = {2'b00, a1_q, 1'b0};
                x3_d  = {1'b0, sum_hi, lo1_q};
                x4_d  = {1'b0, a1_q, 2'b00};
                sel_d = enc_sel;
            end
        end
    end

    // Stage 1 registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q  <= 1'b0;
            a1_q  <= '0;
            b1_q  <= '0;
            lo1_q <= '0;
            cy1_q <= 1'b0;
        end else begin
            v1_q  <= v1_d;
            a1_q  <= a1_d;
            b1_q  <= b1_d;
            lo1_q <= lo1_d;
            cy1_q <= cy1_d;
        end
    end

    // Stage 2 registers, which directly drive the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q  <= 1'b0;
            x1_q  <= '0;
            x2_q  <= '0;
            x3_q  <= '0;
            x4_q  <= '0;
            sel_q <= '0;
        end else begin
            v2_q  <= v2_d;
            x1_q  <= x1_d;
            x2_q  <= x2_d;
            x3_q  <= x3_d;
            x4_q  <= x4_d;
            sel_q <= sel_d;
        end
    end

    assign out_valid = v2_q;
    assign x_1       = x1_q;
    assign x_2       = x2_q;
    assign x_3       = x3_q;
    assign x_4       = x4_q;
    assign BEU_sel   = sel_q;

endmodule
